// File: rtl/mac_operand_loader_pkg.sv
// mac_operand_loader_pkg: shared sizes, operand types and loader FSM states
package mac_operand_loader_pkg;
  localparam int N_ROWS = 8;
  localparam int N_COLS = 8;
  localparam int ACT_W = 4;
  localparam int W_W = 8;
  localparam int BUS_W = 32;
  localparam int BEATS_PER_ROW = N_COLS * W_W / BUS_W;
  localparam int BYTES_PER_BEAT = BUS_W / W_W;
  localparam int N_BEATS = N_ROWS * BEATS_PER_ROW;
  localparam int WCNT_W = $clog2(N_BEATS);
  localparam int ROW_W = $clog2(N_ROWS);
  typedef logic [N_ROWS-1:0][ACT_W-1:0] act_vec_t;
  typedef logic [N_ROWS-1:0][N_COLS-1:0][W_W-1:0] w_mat_t;
  typedef enum logic {BEAT_W, BEAT_ACT} beat_kind_e;
  typedef enum logic {LOAD, COMMIT} loader_state_e;
endpackage

// File: rtl/mac_operand_loader_if.sv
// mac_operand_loader_if: valid/ready beat stream carrying weight or activation payloads
interface mac_operand_loader_if;
  import mac_operand_loader_pkg::*;
  logic in_valid;
  logic in_ready;
  beat_kind_e in_kind;
  logic [BUS_W-1:0] in_data;
  modport master(output in_valid, in_kind, in_data, input in_ready);
  modport slave(input in_valid, in_kind, in_data, output in_ready);
endinterface

// File: rtl/mac_operand_loader_wbank.sv
// mac_wbank: shadow weight bank filled beat by beat, copied whole into the active bank on commit
module mac_wbank
  import mac_operand_loader_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_wr,
  input  logic [WCNT_W-1:0] i_idx,
  input  logic [BUS_W-1:0]  i_data,
  input  logic              i_commit,
  output w_mat_t            o_active
);
  w_mat_t r_shadow, r_active;
  logic [ROW_W-1:0] w_row;
  logic [WCNT_W-ROW_W-1:0] w_part;
  assign w_row = i_idx[WCNT_W-1 -: ROW_W];
  assign w_part = i_idx[WCNT_W-ROW_W-1:0];
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (i_wr)
        for (int c = 0; c < N_COLS; c++)
          if (c / BYTES_PER_BEAT == int'(w_part))
            r_shadow[w_row][c] <= i_data[W_W*(c%BYTES_PER_BEAT) +: W_W];
      if (i_commit) r_active <= r_shadow;
    end
  end
  assign o_active = r_active;
endmodule

// File: rtl/mac_operand_loader.sv
// mac_operand_loader: assembles double-buffered weights and issues act/weight pairs to mac_engine
module mac_operand_loader
  import mac_operand_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  mac_operand_loader_if.slave   bus,
  input  logic                  wabort_i,
  output logic                  w_loaded_o,
  output act_vec_t              act_o,
  output w_mat_t                w_o,
  output logic                  issue_o
);
  loader_state_e r_state, w_next;
  logic [WCNT_W-1:0] r_wcnt;
  logic r_loaded, r_issue;
  act_vec_t r_act;
  w_mat_t r_w, w_active;
  logic w_accept, w_wbeat, w_abeat, w_commit;
  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_wbeat = w_accept & (bus.in_kind == BEAT_W) & ~wabort_i;
  assign w_abeat = w_accept & (bus.in_kind == BEAT_ACT);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) r_state <= LOAD;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == COMMIT) ? LOAD :
             (w_wbeat && r_wcnt == WCNT_W'(N_BEATS - 1)) ? COMMIT : LOAD;
  // activations are held off until a committed matrix exists to pair them with
  always_comb begin
    bus.in_ready = (r_state == LOAD) & ~((bus.in_kind == BEAT_ACT) & ~r_loaded);
    w_commit = (r_state == COMMIT);
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wcnt <= '0;
      r_loaded <= 1'b0;
      r_act <= '0;
      r_w <= '0;
      r_issue <= 1'b0;
    end else begin
      if (wabort_i && r_state == LOAD) r_wcnt <= '0;
      else if (w_wbeat) r_wcnt <= r_wcnt + 1'b1;
      if (w_commit) r_loaded <= 1'b1;
      if (w_abeat) begin
        r_act <= act_vec_t'(bus.in_data);
        r_w <= w_active;
      end
      r_issue <= w_abeat;
    end
  end
  mac_wbank u_wbank (
    .clk      (clk),
    .nrst     (nrst),
    .i_wr     (w_wbeat),
    .i_idx    (r_wcnt),
    .i_data   (bus.in_data),
    .i_commit (w_commit),
    .o_active (w_active)
  );
  assign w_loaded_o = r_loaded;
  assign act_o = r_act;
  assign w_o = r_w;
  assign issue_o = r_issue;
endmodule

// File: tb/tb_mac_operand_loader.sv
// tb_mac_operand_loader: scoreboard bench for the weight/activation operand loader
module tb_mac_operand_loader;
  import mac_operand_loader_pkg::*;
  typedef struct packed {act_vec_t act; w_mat_t w;} exp_t;
  logic clk = 0, nrst = 0, wabort_i = 0;
  logic w_loaded_o, issue_o;
  act_vec_t act_o;
  w_mat_t w_o;
  mac_operand_loader_if bus();
  mac_operand_loader dut (
    .clk        (clk),
    .nrst       (nrst),
    .bus        (bus),
    .wabort_i   (wabort_i),
    .w_loaded_o (w_loaded_o),
    .act_o      (act_o),
    .w_o        (w_o),
    .issue_o    (issue_o)
  );
  always #5 clk = ~clk;
  exp_t sb[$];
  exp_t e;
  int n_tests = 0, n_fail = 0, issue_cnt = 0, run = 0, max_run = 0, waits_sum = 0;
  w_mat_t m_shadow, m_active, ma, mb, mc, md;
  int m_wcnt = 0;
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (nrst && issue_o) begin
      issue_cnt++;
      run++;
      if (run > max_run) max_run = run;
      if (sb.size() == 0) check("sb_unexpected_issue", 1, 0);
      else begin
        e = sb.pop_front();
        check("issue_act", act_o, e.act);
        check("issue_w", w_o, e.w);
      end
    end else run = 0;
  task automatic beat(input beat_kind_e k, input logic [31:0] d, input bit ab = 0);
    int waits = 0;
    bit rdy = 0;
    while (!rdy) begin
      @(negedge clk);
      bus.in_valid = 1;
      bus.in_kind = k;
      bus.in_data = d;
      wabort_i = ab;
      #1 rdy = bus.in_ready;
      @(posedge clk);
      if (!rdy) begin
        waits++;
        if (waits > 20) begin
          check("beat_timeout", waits, 0);
          return;
        end
      end
    end
    waits_sum += waits;
    if (k == BEAT_ACT) sb.push_back({d, m_active});
    else if (ab) m_wcnt = 0;
    else begin
      for (int j = 0; j < 4; j++) m_shadow[m_wcnt/2][4*(m_wcnt%2)+j] = d[8*j +: 8];
      m_wcnt++;
      if (m_wcnt == 16) begin
        m_wcnt = 0;
        m_active = m_shadow;
      end
    end
  endtask
  task automatic wbeat(input w_mat_t m, input int b);
    logic [31:0] d;
    for (int j = 0; j < 4; j++) d[8*j +: 8] = m[b/2][4*(b%2)+j];
    beat(BEAT_W, d);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 0;
      wabort_i = 0;
    end
  endtask
  function automatic w_mat_t rand_mat();
    w_mat_t m;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) m[r][c] = 8'($urandom);
    return m;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 0;
    bus.in_kind = BEAT_W;
    bus.in_data = 0;
    m_shadow = '0;
    m_active = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_act", act_o, 0);
    check("rst_w", w_o, 0);
    check("rst_issue", issue_o, 0);
    check("rst_loaded", w_loaded_o, 0);
    check("rst_rdy", bus.in_ready, 1);
    nrst = 1;
    // activation before any commit must be held off
    @(negedge clk);
    bus.in_valid = 1;
    bus.in_kind = BEAT_ACT;
    bus.in_data = 32'h11111111;
    #1 check("precommit_rdy", bus.in_ready, 0);
    repeat (4) @(posedge clk);
    idle(2);
    check("precommit_issue", issue_cnt, 0);
    check("precommit_act", act_o, 0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) ma[r][c] = 8'(8*r + c);
    for (int b = 0; b < 16; b++) wbeat(ma, b);
    @(negedge clk);
    bus.in_valid = 0;
    #1;
    check("commit_rdy", bus.in_ready, 0);
    check("commit_loaded_pre", w_loaded_o, 0);
    beat(BEAT_ACT, 32'h76543210);
    idle(2);
    check("t1_loaded", w_loaded_o, 1);
    check("t1_issue_cnt", issue_cnt, 1);
    check("t1_act", act_o, 32'h76543210);
    check("t1_w35", w_o[3][5], 29);
    // matrix B loads while issues keep using A
    mb = rand_mat();
    for (int b = 0; b < 7; b++) begin
      wbeat(mb, b);
      beat(BEAT_ACT, $urandom);
    end
    idle(1);
    check("t3_w_still_a", w_o, ma);
    for (int b = 7; b < 16; b++) wbeat(mb, b);
    beat(BEAT_ACT, $urandom);
    idle(2);
    check("t3_w_is_b", w_o, mb);
    md = rand_mat();
    for (int b = 0; b < 5; b++) wbeat(md, b);
    beat(BEAT_W, $urandom, 1);
    mc = rand_mat();
    for (int b = 0; b < 16; b++) wbeat(mc, b);
    beat(BEAT_ACT, $urandom);
    idle(2);
    check("t4_w_is_c", w_o, mc);
    issue_cnt = 0;
    max_run = 0;
    waits_sum = 0;
    for (int i = 0; i < 4; i++) beat(BEAT_ACT, $urandom);
    idle(2);
    check("t5_issue_cnt", issue_cnt, 4);
    check("t5_issue_run", max_run, 4);
    check("t5_waits", waits_sum, 0);
    md = rand_mat();
    for (int b = 0; b < 9; b++) wbeat(md, b);
    @(negedge clk);
    nrst = 0;
    bus.in_valid = 0;
    #1;
    check("t6_act", act_o, 0);
    check("t6_w", w_o, 0);
    check("t6_loaded", w_loaded_o, 0);
    check("t6_issue", issue_o, 0);
    m_shadow = '0;
    m_active = '0;
    m_wcnt = 0;
    @(negedge clk);
    nrst = 1;
    mc = rand_mat();
    for (int b = 0; b < 16; b++) wbeat(mc, b);
    beat(BEAT_ACT, $urandom);
    idle(2);
    check("t6_reload_w", w_o, mc);
    check("t6_reload_loaded", w_loaded_o, 1);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
